fb_writer: RTL and testbench

//   Write-side engine for the 16-bit VGA frame buffer BRAM: drives port A (addra/dina/wea)

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_raster_walk.sv | 72 +++++++
 rtl/fb_writer.sv | 119 +++++++++++
 tb/tb_fb_writer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, command opcodes and FSM state encoding for the frame-buffer
// write engine.
package fb_pkg;

    localparam int FB_W_DEFAULT = 160;
    localparam int FB_H_DEFAULT = 120;
    localparam int AW_DEFAULT   = 15;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_BLIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_BLIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Start-row offset y*pitch as a constant-coefficient shift-and-add.
    function automatic logic [31:0] row_offset(input logic [7:0] y, input int pitch);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (pitch[i]) acc = acc + ({24'd0, y} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_raster_walk.sv
// Raster walker for one draw rectangle: column/row position, running row base,
// frame-buffer address, clip flag and last-pixel flag.
module fb_raster_walk
    import fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEFAULT,
    parameter int FB_H = FB_H_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    x0,
    input  logic [7:0]    y0,
    input  logic [7:0]    w,
    input  logic [7:0]    h,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          clip,
    output logic          last
);

    localparam logic [8:0] W9 = 9'(FB_W);
    localparam logic [8:0] H9 = 9'(FB_H);

    logic [7:0]    x0_q, w_q, h_q;
    logic [7:0]    col_q, row_q;
    logic [8:0]    x_q, y_q;
    logic [AW-1:0] row_base_q;
    logic          row_end;

    assign row_end = (col_q == w_q - 8'd1);
    assign last    = row_end && (row_q == h_q - 8'd1);
    // 9-bit coordinates so columns past the right edge clip instead of wrapping.
    assign clip    = (x_q >= W9) || (y_q >= H9);
    assign addr    = row_base_q + AW'(x_q);

    // NOTE: every register here is state, so it is written with <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
        end else if (start) begin
            x0_q       <= x0;
            w_q        <= w;
            h_q        <= h;
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= {1'b0, x0};
            y_q        <= {1'b0, y0};
            row_base_q <= AW'(row_offset(y0, FB_W));
        end else if (advance) begin
            if (row_end) begin
                col_q      <= '0;
                row_q      <= row_q + 8'd1;
                x_q        <= {1'b0, x0_q};
                y_q        <= y_q + 9'd1;
                row_base_q <= row_base_q + AW'(FB_W);
            end else begin
                col_q <= col_q + 8'd1;
                x_q   <= x_q + 9'd1;
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer port-A write engine: accepts one FILL or BLIT command at a time
// and emits registered BRAM writes in raster order with edge clipping.
module fb_writer
    import fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEFAULT,
    parameter int FB_H = FB_H_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST_BTN,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [7:0]    cmd_x0,
    input  logic [7:0]    cmd_y0,
    input  logic [7:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic [15:0]   cmd_color,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic [15:0]   px_data,
    output logic [AW-1:0] addra,
    output logic [15:0]   dina,
    output logic          wea,
    output logic          busy,
    output logic          done
);

    localparam logic [8:0] W9 = 9'(FB_W);
    localparam logic [8:0] H9 = 9'(FB_H);

    state_t        state_q, state_d;
    logic          op_q;
    logic [15:0]   color_q;
    logic          accept, advance, issue;
    logic [AW-1:0] walk_addr;
    logic          walk_clip, walk_last;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign px_ready  = (state_q == ST_BLIT);
    assign accept    = cmd_valid && cmd_ready;

    fb_raster_walk #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW)) u_walk (
        .clk     (CLK),
        .rst_n   (RST_BTN),
        .start   (accept),
        .x0      (cmd_x0),
        .y0      (cmd_y0),
        .w       (cmd_w),
        .h       (cmd_h),
        .advance (advance),
        .addr    (walk_addr),
        .clip    (walk_clip),
        .last    (walk_last)
    );

    // NOTE: defaults first so no path through this block leaves a value held (no latches).
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_w == 8'd0 || cmd_h == 8'd0)
                        state_d = ST_DONE;
                    else if (cmd_op == OP_BLIT)
                        state_d = ST_BLIT;
                    else if ({1'b0, cmd_x0} >= W9 || {1'b0, cmd_y0} >= H9)
                        state_d = ST_DONE;
                    else
                        state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                advance = 1'b1;
                issue   = !walk_clip;
                if (walk_last) state_d = ST_DONE;
            end
            ST_BLIT: begin
                // Clipped pixels are still consumed so the stream stays aligned.
                if (px_valid) begin
                    advance = 1'b1;
                    issue   = !walk_clip;
                    if (walk_last) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_q <= ST_IDLE;
            op_q    <= OP_FILL;
            color_q <= '0;
            addra   <= '0;
            dina    <= '0;
            wea     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            wea     <= issue;
            done    <= (state_q == ST_DONE);
            if (accept) begin
                op_q    <= cmd_op;
                color_q <= cmd_color;
            end
            if (issue) begin
                addra <= walk_addr;
                dina  <= (op_q == OP_BLIT) ? px_data : color_q;
            end
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Directed and randomized checks of fb_writer against a rectangle/clip reference
// model that lists the expected frame-buffer writes per command.
module tb_fb_writer;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int AW = 15;

    logic          CLK = 1'b0;
    logic          RST_BTN;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [7:0]    cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [15:0]   cmd_color;
    logic          px_valid, px_ready;
    logic [15:0]   px_data;
    logic [AW-1:0] addra;
    logic [15:0]   dina;
    logic          wea, busy, done;

    fb_writer #(.FB_W(W), .FB_H(H), .AW(AW)) dut (
        .CLK       (CLK),
        .RST_BTN   (RST_BTN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_data   (px_data),
        .addra     (addra),
        .dina      (dina),
        .wea       (wea),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    // Observed bus activity, logged on the falling edge.
    wr_t wr_log[$];
    int  done_log[$];
    bit  done_rdy[$];
    int  px_cnt  = 0;
    int  pxr_cnt = 0;

    always @(negedge CLK) begin
        if (wea === 1'b1) wr_log.push_back('{int'(addra), int'(dina), cyc});
        if (px_valid === 1'b1 && px_ready === 1'b1) px_cnt <= px_cnt + 1;
        if (px_ready === 1'b1) pxr_cnt <= pxr_cnt + 1;
        if (done === 1'b1) begin
            done_log.push_back(cyc);
            done_rdy.push_back(cmd_ready === 1'b1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: every in-bounds pixel of the rectangle, in raster order.
    logic [15:0] pix_all[$];
    wr_t         exp_q[$];
    bit          vpat[$];

    function automatic void build_exp(input logic op, input int x0, input int y0,
                                      input int w, input int h, input logic [15:0] color);
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (x0 + c < W && y0 + r < H)
                    exp_q.push_back('{(y0 + r) * W + x0 + c,
                                      int'(op ? pix_all[r * w + c] : color), 0});
            end
        end
    endfunction

    task automatic compare_writes(input string tag, input int wr0);
        int n;
        n = wr_log.size() - wr0;
        check({tag, "/n_writes"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({tag, "/addr"}, wr_log[wr0 + i].addr, exp_q[i].addr);
            check({tag, "/data"}, wr_log[wr0 + i].data, exp_q[i].data);
        end
    endtask

    task automatic offer_cmd(input logic op, input int x0, input int y0, input int w,
                             input int h, input logic [15:0] color);
        cmd_op    = op;
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = color;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int budget;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 1000) begin
            step();
            budget++;
        end
        check({tag, "/cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    task automatic scramble_cmd();
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_x0    = 8'($urandom);
        cmd_y0    = 8'($urandom);
        cmd_w     = 8'($urandom);
        cmd_h     = 8'($urandom);
        cmd_color = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int dn0);
        int budget;
        budget = 0;
        while (done_log.size() == dn0 && budget < 20000) begin
            step();
            budget++;
        end
        step();
        step();
        check({tag, "/done_pulses"}, done_log.size() - dn0, 1);
    endtask

    task automatic run_cmd(input string tag, input logic op, input int x0, input int y0,
                           input int w, input int h, input logic [15:0] color,
                           input int gap_pct);
        int  wr0, px0, pxr0, dn0, acc_cyc, last_px_cyc, k, budget, exp_done;
        bit  take;
        pix_all.delete();
        if (op) for (int i = 0; i < w * h; i++) pix_all.push_back(16'($urandom));
        build_exp(op, x0, y0, w, h, color);
        wr0  = wr_log.size();
        px0  = px_cnt;
        pxr0 = pxr_cnt;
        dn0  = done_log.size();
        offer_cmd(op, x0, y0, w, h, color);
        wait_ready(tag);
        acc_cyc = cyc;
        step();
        scramble_cmd();
        k = 0;
        last_px_cyc = -1;
        budget = 0;
        while (done_log.size() == dn0 && budget < 20000) begin
            if (px_ready === 1'b1 && vpat.size() > 0) take = vpat.pop_front();
            else take = ($urandom_range(99) >= gap_pct);
            px_valid = take && (k < pix_all.size());
            px_data  = (k < pix_all.size()) ? pix_all[k] : 16'($urandom);
            if (px_valid && px_ready === 1'b1) begin
                k++;
                last_px_cyc = cyc;
            end
            step();
            budget++;
        end
        px_valid = 1'b0;
        step();
        step();
        check({tag, "/done_pulses"}, done_log.size() - dn0, 1);
        if (done_log.size() > dn0) begin
            if (w * h == 0 || (!op && (x0 >= W || y0 >= H))) exp_done = acc_cyc + 2;
            else if (!op) exp_done = acc_cyc + w * h + 2;
            else exp_done = last_px_cyc + 2;
            check({tag, "/done_cycle"}, done_log[dn0], exp_done);
            check({tag, "/ready_at_done"}, 32'(done_rdy[dn0]), 1);
        end
        compare_writes(tag, wr0);
        check({tag, "/px_consumed"}, px_cnt - px0, op ? w * h : 0);
        if (!op || w * h == 0) check({tag, "/px_ready_cycles"}, pxr_cnt - pxr0, 0);
    endtask

    initial begin
        int base, acc, dn0, wr0, n_rst, budget;

        RST_BTN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        px_valid  = 1'b0;
        px_data   = '0;

        // Reset state.
        repeat (3) step();
        check("rst/wea", 32'(wea), 0);
        check("rst/busy", 32'(busy), 0);
        check("rst/done", 32'(done), 0);
        check("rst/px_ready", 32'(px_ready), 0);
        check("rst/addra", 32'(addra), 0);
        check("rst/dina", 32'(dina), 0);
        RST_BTN = 1'b1;
        step();
        check("rst/cmd_ready", 32'(cmd_ready), 1);

        // Basic FILL: rows 3 and 4, columns 2..5.
        base = wr_log.size();
        run_cmd("fill_basic", 1'b0, 2, 3, 4, 2, 16'h0F00, 0);
        if (wr_log.size() > base + 4) begin
            check("fill_basic/first_addr", wr_log[base].addr, 482);
            check("fill_basic/row2_addr", wr_log[base + 4].addr, 642);
        end

        // BLIT with one gap in the pixel stream.
        base = wr_log.size();
        vpat = '{1'b1, 1'b0, 1'b1, 1'b1};
        run_cmd("blit_gap", 1'b1, 0, 0, 3, 1, 16'h0000, 0);
        if (wr_log.size() > base + 2) begin
            check("blit_gap/gap_spacing", wr_log[base + 1].cyc - wr_log[base].cyc, 2);
            check("blit_gap/tail_spacing", wr_log[base + 2].cyc - wr_log[base + 1].cyc, 1);
        end
        vpat.delete();

        // Clipping at the bottom-right corner.
        base = wr_log.size();
        run_cmd("clip_fill", 1'b0, 158, 119, 4, 3, 16'h7E0F, 0);
        if (wr_log.size() > base) check("clip_fill/first_addr", wr_log[base].addr, 19198);
        run_cmd("clip_blit", 1'b1, 158, 119, 4, 3, 16'h0000, 25);

        // Degenerate commands.
        run_cmd("w0_fill", 1'b0, 5, 5, 0, 4, 16'h1111, 0);
        run_cmd("w0_blit", 1'b1, 5, 5, 0, 4, 16'h0000, 0);
        run_cmd("h0_blit", 1'b1, 5, 5, 3, 0, 16'h0000, 0);
        run_cmd("x200_fill", 1'b0, 200, 5, 3, 3, 16'h2222, 0);

        // Back-to-back: second command held valid while the first runs.
        pix_all.delete();
        build_exp(1'b0, 10, 10, 5, 2, 16'h1234);
        wr0 = wr_log.size();
        offer_cmd(1'b0, 10, 10, 5, 2, 16'h1234);
        wait_ready("b2b_a");
        acc = cyc;
        step();
        offer_cmd(1'b0, 20, 20, 3, 3, 16'hABCD);
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 1000) begin
            step();
            budget++;
        end
        check("b2b/second_accept_cycle", cyc, acc + 12);
        compare_writes("b2b_a", wr0);
        step();
        scramble_cmd();
        dn0 = done_log.size();
        wr0 = wr_log.size();
        build_exp(1'b0, 20, 20, 3, 3, 16'hABCD);
        wait_done("b2b_b", dn0);
        compare_writes("b2b_b", wr0);

        // Reset in the middle of a large FILL.
        offer_cmd(1'b0, 0, 0, 100, 100, 16'h5A5A);
        wait_ready("rst_mid");
        step();
        scramble_cmd();
        wr0 = wr_log.size();
        dn0 = done_log.size();
        budget = 0;
        while (wr_log.size() - wr0 < 50 && budget < 500) begin
            step();
            budget++;
        end
        check("rst_mid/reached_50", 32'(wr_log.size() - wr0 >= 50), 1);
        RST_BTN = 1'b0;
        #1;
        check("rst_mid/wea", 32'(wea), 0);
        check("rst_mid/busy", 32'(busy), 0);
        check("rst_mid/done", 32'(done), 0);
        n_rst = wr_log.size();
        repeat (3) step();
        RST_BTN = 1'b1;
        step();
        check("rst_mid/cmd_ready", 32'(cmd_ready), 1);
        repeat (4) step();
        check("rst_mid/no_done", done_log.size() - dn0, 0);
        check("rst_mid/no_more_writes", wr_log.size() - n_rst, 0);
        run_cmd("after_rst", 1'b0, 30, 40, 6, 3, 16'hC0DE, 0);

        // Randomized commands, including clipped and degenerate shapes.
        for (int i = 0; i < 14; i++) begin
            run_cmd("rand", 1'($urandom), int'($urandom_range(175)), int'($urandom_range(135)),
                    int'($urandom_range(20)), int'($urandom_range(12)),
                    16'($urandom), 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
